// File: rtl/uart_prog_dump_pkg.sv
// ============================================================================
//  Module   : uart_prog_dump_pkg
//  Brief    : Shared FSM encodings and UART frame constants for the RAM dumper.
//             Optional feature macro: DUMP_CHECKSUM_EN (adds the CSUM state).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_prog_dump_pkg;

    // 25 MHz / 115200 baud
    localparam int   DEFAULT_CLK_DIV = 217;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam int   DATA_BITS  = 8;
    localparam int   FRAME_BITS = DATA_BITS + 2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RD   = 3'd2,
        S_WAIT = 3'd3,
        S_SEND = 3'd4,
`ifdef DUMP_CHECKSUM_EN
        S_CSUM = 3'd5,
`endif
        S_FIN  = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/uart_prog_dump_tx_ser.sv
// ============================================================================
//  Module   : uart_prog_dump_tx_ser
//  Brief    : 8N1 UART serializer. Bit-period counter plus a 10-bit frame
//             shifter; tx_done pulses in the last cycle of the stop bit.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_prog_dump_tx_ser
    import uart_prog_dump_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic                 clk_ram,
    input  logic                 reset,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] data,
    output logic                 txd,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [3:0]  BIT_LAST = 4'(FRAME_BITS - 1);

    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [3:0]            bit_q,   bit_d;
    logic [15:0]           div_q,   div_d;
    logic                  busy_q,  busy_d;

    // Frame register: the shifter idles at all ones, so txd rests high
    // without any extra muxing and comes straight from a flop.
    always_ff @(posedge clk_ram or negedge reset) begin
        if (!reset) begin
            shift_q <= '1;
            bit_q   <= '0;
            div_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            busy_q  <= busy_d;
        end
    end

    // Bit timing: every CLK_DIV cycles shift in a one; a load is only
    // accepted while idle.
    always_comb begin
        shift_d = shift_q;
        bit_d   = bit_q;
        div_d   = div_q;
        busy_d  = busy_q;
        tx_done = 1'b0;
        if (busy_q) begin
            if (div_q == DIV_LAST) begin
                div_d   = '0;
                shift_d = {STOP_BIT, shift_q[FRAME_BITS-1:1]};
                if (bit_q == BIT_LAST) begin
                    bit_d   = '0;
                    busy_d  = 1'b0;
                    tx_done = 1'b1;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end else begin
                div_d = div_q + 16'd1;
            end
        end else if (load) begin
            shift_d = {STOP_BIT, data, START_BIT};
            bit_d   = '0;
            div_d   = '0;
            busy_d  = 1'b1;
        end
    end

    assign txd     = shift_q[0];
    assign tx_busy = busy_q;

endmodule

`default_nettype wire

// File: rtl/uart_prog_dump.sv
// ============================================================================
//  Module   : uart_prog_dump
//  Brief    : Streams a block of program RAM out of a UART TX line (8N1) while
//             holding the CPU suspended. Optional macro DUMP_CHECKSUM_EN adds
//             a trailing modulo-256 checksum frame.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_prog_dump
    import uart_prog_dump_pkg::*;
#(
    parameter int          CLK_DIV  = DEFAULT_CLK_DIV,
    parameter logic [15:0] RST_ADDR = 16'h0600
) (
    input  logic        clk_ram,
    input  logic        reset,
    input  logic        start,
    input  logic        start_addr_sel,
    input  logic [15:0] start_addr,
    input  logic [15:0] length,
    input  logic        ram_grant,
    output logic [15:0] raddr,
    output logic        read_en,
    input  logic [7:0]  rdata,
    output logic        ask_for_ram,
    output logic        busy,
    output logic        done,
    output logic        serial_txd
);

    state_t      state_q, state_d;
    logic [15:0] addr_q,  addr_d;
    logic [16:0] rem_q,   rem_d;
    logic        ser_load;
    logic [7:0]  ser_data;
    logic        tx_busy;
    logic        tx_done;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
    logic        csum_sent_q, csum_sent_d;
`endif

    uart_prog_dump_tx_ser #(
        .CLK_DIV (CLK_DIV)
    ) u_tx_ser (
        .clk_ram (clk_ram),
        .reset   (reset),
        .load    (ser_load),
        .data    (ser_data),
        .txd     (serial_txd),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    // State, address and byte-count registers.
    always_ff @(posedge clk_ram or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
`ifdef DUMP_CHECKSUM_EN
            sum_q       <= '0;
            csum_sent_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
`ifdef DUMP_CHECKSUM_EN
            sum_q       <= sum_d;
            csum_sent_q <= csum_sent_d;
`endif
        end
    end

    // Transfer sequencing: request RAM, read one byte, hand it to the
    // serializer, and after its stop bit go straight back to a read so the
    // next start bit follows within three cycles when grant stays high.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        ser_load    = 1'b0;
        ser_data    = rdata;
        read_en     = 1'b0;
`ifdef DUMP_CHECKSUM_EN
        sum_d       = sum_q;
        csum_sent_d = csum_sent_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d      = start_addr_sel ? start_addr : RST_ADDR;
                    rem_d       = {1'b0, length};
`ifdef DUMP_CHECKSUM_EN
                    sum_d       = '0;
                    csum_sent_d = 1'b0;
`endif
                    state_d     = (length == 16'd0) ? S_FIN : S_REQ;
                end
            end
            S_REQ: begin
                if (ram_grant) begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                // Grant is re-checked here: a lost grant costs a trip
                // through REQ rather than an unsafe read.
                if (ram_grant) begin
                    read_en = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (!tx_busy) begin
                    ser_load = 1'b1;
`ifdef DUMP_CHECKSUM_EN
                    sum_d    = sum_q + rdata;
`endif
                    state_d  = S_SEND;
                end
            end
            S_SEND: begin
                // Grant is ignored here so a byte in flight always completes.
                if (tx_done) begin
                    rem_d  = rem_q - 17'd1;
                    addr_d = addr_q + 16'd1;
                    if (rem_q != 17'd1) begin
                        state_d = S_RD;
                    end else begin
`ifdef DUMP_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_FIN;
`endif
                    end
                end
            end
`ifdef DUMP_CHECKSUM_EN
            S_CSUM: begin
                if (!csum_sent_q && !tx_busy) begin
                    ser_load    = 1'b1;
                    ser_data    = sum_q;
                    csum_sent_d = 1'b1;
                end else if (tx_done) begin
                    state_d = S_FIN;
                end
            end
`endif
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy        = (state_q != S_IDLE) && (state_q != S_FIN);
    assign ask_for_ram = busy;
    assign done        = (state_q == S_FIN);
    assign raddr       = addr_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_prog_dump.sv
// ============================================================================
//  Module   : tb_uart_prog_dump
//  Brief    : Self-checking bench for uart_prog_dump: a RAM model, a UART
//             receiver, and a reference list of expected bytes computed
//             directly from the memory contents.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_prog_dump;

    localparam int CLK_DIV = 4;
    localparam int MID     = CLK_DIV / 2;
    localparam int LAST_C  = MID + 9 * CLK_DIV;

    logic        clk_ram = 1'b0;
    logic        reset;
    logic        start;
    logic        start_addr_sel;
    logic [15:0] start_addr;
    logic [15:0] length;
    logic        ram_grant = 1'b1;
    logic [15:0] raddr;
    logic        read_en;
    logic [7:0]  rdata = 8'h00;
    logic        ask_for_ram;
    logic        busy;
    logic        done;
    logic        serial_txd;

    logic [7:0]  mem [0:65535];
    logic [7:0]  rx_q  [$];
    logic [7:0]  exp_q [$];
    logic [7:0]  mon_b;
    logic        mon_abort;

    int checks    = 0;
    int failures  = 0;
    int bad_rd    = 0;
    int bad_ask   = 0;
    int grant_mode = 0;   // 0: tied high, 1: random drops, 2: held low

    uart_prog_dump #(
        .CLK_DIV  (CLK_DIV),
        .RST_ADDR (16'h0600)
    ) dut (
        .clk_ram        (clk_ram),
        .reset          (reset),
        .start          (start),
        .start_addr_sel (start_addr_sel),
        .start_addr     (start_addr),
        .length         (length),
        .ram_grant      (ram_grant),
        .raddr          (raddr),
        .read_en        (read_en),
        .rdata          (rdata),
        .ask_for_ram    (ask_for_ram),
        .busy           (busy),
        .done           (done),
        .serial_txd     (serial_txd)
    );

    always #5 clk_ram = ~clk_ram;

    // Synchronous RAM: data valid the cycle after the strobe.
    always @(posedge clk_ram) begin
        if (read_en) rdata <= mem[raddr];
    end

    // Bus-protocol watchers.
    always @(negedge clk_ram) begin
        if (read_en && !ram_grant)   bad_rd  <= bad_rd + 1;
        if (read_en && !ask_for_ram) bad_ask <= bad_ask + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Grant driver, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge clk_ram);
            #2;
            case (grant_mode)
                0:       ram_grant = 1'b1;
                1:       ram_grant = ($urandom_range(0, 3) != 0);
                default: ram_grant = 1'b0;
            endcase
        end
    end

    // UART receiver: mid-bit sampling; frames cut by reset are discarded.
    initial begin
        forever begin
            @(negedge clk_ram);
            if (reset && serial_txd == 1'b0) begin
                mon_abort = 1'b0;
                mon_b     = 8'h00;
                for (int c = 1; c <= LAST_C; c++) begin
                    @(negedge clk_ram);
                    if (!reset) mon_abort = 1'b1;
                    if (!mon_abort) begin
                        if (c == MID) chk("start_bit", {31'd0, serial_txd}, 32'd0);
                        else if (c == LAST_C) chk("stop_bit", {31'd0, serial_txd}, 32'd1);
                        else if (c > MID && (c - MID) % CLK_DIV == 0)
                            mon_b[(c - MID) / CLK_DIV - 1] = serial_txd;
                    end
                end
                if (!mon_abort) rx_q.push_back(mon_b);
            end
        end
    end

    task automatic tick();
        @(posedge clk_ram);
        #2;
    endtask

    // Reference model: the bytes a dump must produce, straight from memory.
    task automatic build_exp(input logic sel, input logic [15:0] a, input logic [15:0] n);
        logic [15:0] base;
        logic [7:0]  s;
        base = sel ? a : 16'h0600;
        s    = 8'h00;
        exp_q.delete();
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back(mem[16'(int'(base) + i)]);
            s = s + mem[16'(int'(base) + i)];
        end
`ifdef DUMP_CHECKSUM_EN
        if (n != 16'd0) exp_q.push_back(s);
`endif
    endtask

    task automatic pulse_start(input logic sel, input logic [15:0] a, input logic [15:0] n);
        tick();
        start_addr_sel = sel;
        start_addr     = a;
        length         = n;
        start          = 1'b1;
        tick();
        start          = 1'b0;
    endtask

    task automatic finish_dump(input int n);
        logic got;
        got = 1'b0;
        for (int c = 0; c < 300 * (n + 2) && !got; c++) begin
            @(negedge clk_ram);
            if (done) got = 1'b1;
        end
        chk("done_seen", {31'd0, got}, 32'd1);
        @(negedge clk_ram);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("ask_after_done", {31'd0, ask_for_ram}, 32'd0);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk_ram);
        chk("frame_count", rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            chk("frame_byte", (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hFFFF_FFFF, {24'd0, exp_q[i]});
        end
    endtask

    task automatic run(input logic sel, input logic [15:0] a, input logic [15:0] n);
        rx_q.delete();
        build_exp(sel, a, n);
        pulse_start(sel, a, n);
        finish_dump(int'(n));
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: observed=hang expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          stall_bad;
        logic        seen;
        logic        sel;
        logic [15:0] a;
        logic [15:0] n;

        reset          = 1'b0;
        start          = 1'b0;
        start_addr_sel = 1'b0;
        start_addr     = 16'h0000;
        length         = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        // Reset state
        repeat (3) @(negedge clk_ram);
        chk("rst_raddr", {16'd0, raddr}, 32'd0);
        chk("rst_read_en", {31'd0, read_en}, 32'd0);
        chk("rst_ask", {31'd0, ask_for_ram}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_txd", {31'd0, serial_txd}, 32'd1);
        tick();
        reset = 1'b1;

        // Default start address, three bytes, grant tied high
        mem[16'h0600] = 8'h11;
        mem[16'h0601] = 8'h22;
        mem[16'h0602] = 8'h33;
        rx_q.delete();
        build_exp(1'b0, 16'h1234, 16'd3);
        pulse_start(1'b0, 16'h1234, 16'd3);
        @(negedge clk_ram);
        chk("ask_rise", {31'd0, ask_for_ram}, 32'd1);
        chk("busy_rise", {31'd0, busy}, 32'd1);
        finish_dump(3);

        // Zero length: immediate done, no request, line idle
        rx_q.delete();
        pulse_start(1'b1, 16'h0100, 16'd0);
        @(negedge clk_ram);
        chk("len0_done", {31'd0, done}, 32'd1);
        chk("len0_ask", {31'd0, ask_for_ram}, 32'd0);
        @(negedge clk_ram);
        chk("len0_done_end", {31'd0, done}, 32'd0);
        chk("len0_ask_end", {31'd0, ask_for_ram}, 32'd0);
        repeat (10) @(negedge clk_ram);
        chk("len0_frames", rx_q.size(), 32'd0);

        // Address wrap
        mem[16'hFFFF] = 8'hAA;
        mem[16'h0000] = 8'h55;
        run(1'b1, 16'hFFFF, 16'd2);

        // Grant withheld, then granted with random mid-transfer drops
        grant_mode = 2;
        rx_q.delete();
        build_exp(1'b1, 16'h2000, 16'd3);
        pulse_start(1'b1, 16'h2000, 16'd3);
        stall_bad = 0;
        repeat (50) begin
            @(negedge clk_ram);
            if (read_en || !serial_txd) stall_bad++;
        end
        chk("stall_idle", stall_bad, 32'd0);
        chk("stall_ask", {31'd0, ask_for_ram}, 32'd1);
        grant_mode = 1;
        finish_dump(3);
        grant_mode = 0;

        // Start pulse while busy is ignored
        rx_q.delete();
        build_exp(1'b1, 16'h3000, 16'd3);
        pulse_start(1'b1, 16'h3000, 16'd3);
        repeat (45) tick();
        pulse_start(1'b1, 16'h4000, 16'd5);
        finish_dump(3);

        // Reset in the middle of a byte
        rx_q.delete();
        pulse_start(1'b1, 16'h5000, 16'd2);
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk_ram);
            if (!serial_txd) seen = 1'b1;
        end
        chk("abort_frame_started", {31'd0, seen}, 32'd1);
        repeat (10) @(negedge clk_ram);
        tick();
        reset = 1'b0;
        #1;
        chk("abort_txd", {31'd0, serial_txd}, 32'd1);
        chk("abort_ask", {31'd0, ask_for_ram}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        repeat (3) tick();
        reset = 1'b1;
        repeat (50) tick();
        chk("abort_idle", {31'd0, busy}, 32'd0);

        // Checksum frame (present only when the feature is built in)
        mem[16'h6000] = 8'h80;
        mem[16'h6001] = 8'h90;
        run(1'b1, 16'h6000, 16'd2);

        // Randomized dumps
        for (int k = 0; k < 10; k++) begin
            sel        = 1'($urandom_range(0, 1));
            a          = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            n          = 16'($urandom_range(0, 5));
            grant_mode = $urandom_range(0, 1);
            run(sel, a, n);
        end
        grant_mode = 0;

        chk("read_without_grant", bad_rd, 32'd0);
        chk("read_without_ask", bad_ask, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
